// File: rtl/stopwatch_pkg.sv
// Shared types, constants and the 4-digit BCD increment helper for the
// multi-channel stopwatch.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        SwIdle,
        SwRun,
        SwPause,
        SwRunSplit,
        SwPauseSplit
    } sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    typedef struct packed {
        logic        wrap;
        logic [15:0] value;
    } bcd4_inc_t;

    // Ripple a +1 through four BCD digits; wrap is set when 9999 rolls over to 0000.
    function automatic bcd4_inc_t bcd4_inc(input logic [15:0] v);
        bcd4_inc_t  r;
        logic       carry;
        bcd_digit_t digit;
        carry = 1'b1;
        r     = '0;
        for (int i = 0; i < 4; i++) begin
            digit = v[i*4 +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    r.value[i*4 +: 4] = 4'd0;
                end else begin
                    r.value[i*4 +: 4] = digit + 4'd1;
                    carry             = 1'b0;
                end
            end else begin
                r.value[i*4 +: 4] = digit;
            end
        end
        r.wrap = carry;
        return r;
    endfunction

endpackage

// File: rtl/sw_channel.sv
// One stopwatch channel: run/pause/split FSM, BCD counter and split register.
// Commands arriving here are already qualified by the channel selection.
module sw_channel
    import stopwatch_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        tick_i,
    input  logic        trig_i,
    input  logic        split_i,
    input  logic        clear_i,
    output logic [15:0] count_o,
    output logic [15:0] split_reg_o,
    output logic        running_o,
    output logic        split_active_o
);

    sw_state_t   state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] split_q, split_d;
    logic        running_q, split_act_q;
    bcd4_inc_t   inc;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        split_d = split_q;
        inc     = bcd4_inc(count_q);

        // Increment depends on the state held during this cycle, not the next one.
        if (tick_i && (state_q == SwRun || state_q == SwRunSplit)) begin
`ifdef STOPWATCH_SATURATE_EN
            count_d = inc.wrap ? BCD_MAX : inc.value;
`else
            count_d = inc.wrap ? 16'h0000 : inc.value;
`endif
        end

        if (clear_i) begin
            state_d = SwIdle;
            count_d = '0;
            split_d = '0;
        end else if (trig_i) begin
            unique case (state_q)
                SwIdle:       state_d = SwRun;
                SwRun:        state_d = SwPause;
                SwPause:      state_d = SwRun;
                SwRunSplit:   state_d = SwPauseSplit;
                SwPauseSplit: state_d = SwRunSplit;
                default:      state_d = SwIdle;
            endcase
        end else if (split_i) begin
            unique case (state_q)
                SwRun: begin
                    state_d = SwRunSplit;
                    split_d = count_q;
                end
                SwRunSplit:   state_d = SwRun;
                SwPauseSplit: state_d = SwPause;
                default:      state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= SwIdle;
            count_q     <= '0;
            split_q     <= '0;
            running_q   <= 1'b0;
            split_act_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            split_q     <= split_d;
            running_q   <= (state_d == SwRun) || (state_d == SwRunSplit);
            split_act_q <= (state_d == SwRunSplit) || (state_d == SwPauseSplit);
        end
    end

    assign count_o        = count_q;
    assign split_reg_o    = split_q;
    assign running_o      = running_q;
    assign split_active_o = split_act_q;

endmodule

// File: rtl/multi_stopwatch.sv
// N_CH stopwatches sharing one prescaler, with channel selection and display mux.
// Define STOPWATCH_SATURATE_EN to make channels hold at 999.9 instead of wrapping.
module multi_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned SEL_W    = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig,
    input  logic             split,
    input  logic             clear,
    input  logic             toggle,
    output logic [SEL_W-1:0] sel,
    output logic [15:0]      time_reading,
    output logic [N_CH-1:0]  running,
    output logic [N_CH-1:0]  split_active
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PresLast = PW'(TICK_DIV - 1);
    localparam logic [SEL_W-1:0] SelLast = SEL_W'(N_CH - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             tick;
    logic [15:0]      counts     [N_CH];
    logic [15:0]      split_regs [N_CH];

    assign tick = (presc_q == PresLast);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        sel_d   = sel_q;
        if (toggle) begin
            sel_d = (sel_q == SelLast) ? '0 : sel_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            sel_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
        end
    end

    // Commands are steered by the pre-toggle selection.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic hit;
        assign hit = (sel_q == SEL_W'(i));

        sw_channel u_ch (
            .clk_i          (clk),
            .reset_i        (reset),
            .tick_i         (tick),
            .trig_i         (trig & hit),
            .split_i        (split & hit),
            .clear_i        (clear & hit),
            .count_o        (counts[i]),
            .split_reg_o    (split_regs[i]),
            .running_o      (running[i]),
            .split_active_o (split_active[i])
        );
    end

    always_comb begin
        time_reading = split_active[sel_q] ? split_regs[sel_q] : counts[sel_q];
    end

    assign sel = sel_q;

endmodule
